muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execute unit, directly downstream of the opcode decoder.
- Consumes the decoder's mul_en (R-type, funct7 = 0000001) plus funct3 and register operands; produces the rd result and a writeback tag.
- Multiply results take 2 cycles; divide/remainder take a 32-iteration restoring sequence.
- The pipeline stalls on ready = 0 and writes back on result_valid.

---
 rtl/muldiv_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit.
// Multiplies finish in a single product stage. Divides run a restoring
// sequence on magnitudes, one quotient bit per cycle, with the sign fix-up
// applied on the way into DONE. Divide-by-zero and signed-overflow divides
// skip the iteration and pass through the one-cycle result stage, so they
// have the same latency as a multiply.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [TAG_W-1:0] rd_in,
    input  logic             flush,
    output logic             ready,
    output logic             result_valid,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] rd_out
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q,  state_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [XLEN-1:0]    opa_q,    opa_d;     // multiplicand, or dividend magnitude shifting out MSB-first
    logic [XLEN-1:0]    opb_q,    opb_d;     // multiplier, or divisor magnitude
    logic               sign_a_q, sign_a_d;  // operand treated as signed and negative
    logic               sign_b_q, sign_b_d;
    logic [XLEN-1:0]    rem_q,    rem_d;
    logic [XLEN-1:0]    quot_q,   quot_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               valid_q,  valid_d;
    logic               ready_q,  ready_d;
    logic [TAG_W-1:0]   rd_q,     rd_d;

    // decode helpers for the incoming instruction
    logic a_signed_s, b_signed_s, neg_a_s, neg_b_s;
    logic div_zero_s, ovf_s, special_s;
    // datapath helpers for the in-flight operation
    logic [2*XLEN-1:0]  ext_a_s, ext_b_s, prod_s;
    logic [XLEN:0]      shift_s, diff_s;
    logic               qbit_s;
    logic [XLEN-1:0]    rem_next_s, quot_next_s, quot_fix_s, rem_fix_s;

    // Operand signedness and special-case detection for an instruction being accepted
    always_comb begin
        if (funct3[2]) begin
            a_signed_s = ~funct3[0];
            b_signed_s = ~funct3[0];
        end else begin
            a_signed_s = (funct3[1:0] == 2'd1) | (funct3[1:0] == 2'd2);
            b_signed_s = (funct3[1:0] == 2'd1);
        end
        neg_a_s    = a_signed_s & op_a[XLEN-1];
        neg_b_s    = b_signed_s & op_b[XLEN-1];
        div_zero_s = funct3[2] & (op_b == ZERO);
        ovf_s      = funct3[2] & ~funct3[0] & (op_a == INT_MIN) & (op_b == ALL_ONES);
        special_s  = div_zero_s | ovf_s;
    end

    // Product, one restoring-division step and the signed fix-up of the final step
    always_comb begin
        ext_a_s     = {{XLEN{sign_a_q}}, opa_q};
        ext_b_s     = {{XLEN{sign_b_q}}, opb_q};
        prod_s      = ext_a_s * ext_b_s;
        shift_s     = {rem_q, opa_q[XLEN-1]};
        diff_s      = shift_s - {1'b0, opb_q};
        qbit_s      = ~diff_s[XLEN];
        if (qbit_s) begin
            rem_next_s = diff_s[XLEN-1:0];
        end else begin
            rem_next_s = shift_s[XLEN-1:0];
        end
        quot_next_s = {quot_q[XLEN-2:0], qbit_s};
        if (sign_a_q ^ sign_b_q) begin
            quot_fix_s = -quot_next_s;
        end else begin
            quot_fix_s = quot_next_s;
        end
        if (sign_a_q) begin
            rem_fix_s = -rem_next_s;
        end else begin
            rem_fix_s = rem_next_s;
        end
    end

    // Next-state and next-output logic of the control FSM
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rd_d     = rd_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    funct3_d = funct3;
                    rd_d     = rd_in;
                    sign_a_d = neg_a_s;
                    sign_b_d = neg_b_s;
                    rem_d    = ZERO;
                    quot_d   = ZERO;
                    // divides work on magnitudes; special cases keep raw operands
                    if (funct3[2] & neg_a_s & ~special_s) begin
                        opa_d = -op_a;
                    end else begin
                        opa_d = op_a;
                    end
                    if (funct3[2] & neg_b_s & ~special_s) begin
                        opb_d = -op_b;
                    end else begin
                        opb_d = op_b;
                    end
                    if (~funct3[2] | special_s) begin
                        state_d = S_MUL;
                    end else begin
                        state_d = S_DIV;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    if (funct3_q[2]) begin
                        if (opb_q == ZERO) begin
                            result_d = funct3_q[1] ? opa_q : ALL_ONES;
                        end else begin
                            result_d = funct3_q[1] ? ZERO : INT_MIN;
                        end
                    end else if (funct3_q[1:0] == 2'd0) begin
                        result_d = prod_s[XLEN-1:0];
                    end else begin
                        result_d = prod_s[2*XLEN-1:XLEN];
                    end
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d  = rem_next_s;
                    quot_d = quot_next_s;
                    opa_d  = {opa_q[XLEN-2:0], 1'b0};
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_d  = S_DONE;
                        result_d = funct3_q[1] ? rem_fix_s : quot_fix_s;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                valid_d = ~flush;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            funct3_q <= 3'd0;
            opa_q    <= ZERO;
            opb_q    <= ZERO;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            rem_q    <= ZERO;
            quot_q   <= ZERO;
            cnt_q    <= {CNT_W{1'b0}};
            result_q <= ZERO;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            rd_q     <= {TAG_W{1'b0}};
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            rd_q     <= rd_d;
        end
    end

    assign ready        = ready_q;
    assign result_valid = valid_q;
    assign result       = result_q;
    assign rd_out       = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes the hand-computed
// result, tag and expected valid cycle; a negedge monitor pops and compares
// whenever result_valid is seen.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        ready;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .flush(flush),
        .ready(ready), .result_valid(result_valid), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: compare every valid pulse against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (result_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", {31'd0, result_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
                check("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int k);
        int g;
        g = 0;
        @(negedge clk);
        while (ready !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("ready_before_issue", {31'd0, ready}, 32'd1);
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
        @(posedge clk);
        #1;
        k = cyc;
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while (sb_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat);
        int   k;
        logic busy_ok;
        exp_t e;
        issue(f, a, b, rd, k);
        e.res = exp; e.rd = rd; e.cyc = k + lat;
        sb_q.push_back(e);
        busy_ok = 1'b1;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (ready !== 1'b0) busy_ok = 1'b0;
        end
        check("ready_low_while_busy", {31'd0, busy_ok}, 32'd1);
        drain("drain");
    endtask

    initial begin
        int   k;
        int   acc_cyc;
        logic busy_ok;
        exp_t e;
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0;
        op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_valid", {31'd0, result_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rd", {27'd0, rd_out}, 32'd0);
        rst = 1'b0;

        // multiply variants: 2-cycle latency
        run(3'd0, 32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 2);
        run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 2);
        run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, 2);
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 2);

        // divide/remainder: 33-cycle latency
        run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7,  32'hFFFF_FFFD, 33);
        run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8,  32'hFFFF_FFFF, 33);
        run(3'd5, 32'd100,       32'd7, 5'd10, 32'd14,        33);
        run(3'd7, 32'd100,       32'd7, 5'd11, 32'd2,         33);
        run(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd13, 32'd1,         33);

        // divide by zero and signed overflow: 2-cycle latency
        run(3'd4, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 2);
        run(3'd7, 32'd5,         32'd0,         5'd15, 32'd5,         2);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 2);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         2);

        // reset mid-divide: abandoned, no later pulse
        issue(3'd5, 32'd100000, 32'd3, 5'd1, k);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midreset_ready", {31'd0, ready}, 32'd1);
        check("midreset_valid", {31'd0, result_valid}, 32'd0);
        check("midreset_result", result, 32'd0);
        repeat (45) @(negedge clk);

        // flush mid-divide: no pulse, ready next cycle, then a normal multiply
        issue(3'd5, 32'd1000, 32'd3, 5'd2, k);
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_ready", {31'd0, ready}, 32'd1);
        check("flush_valid", {31'd0, result_valid}, 32'd0);
        repeat (40) @(negedge clk);
        run(3'd0, 32'd3, 32'd4, 5'd18, 32'd12, 2);

        // busy: start pulsed with junk during a divide, then held through DONE
        issue(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd12, k);
        e.res = 32'hFFFF_FFF2; e.rd = 5'd12; e.cyc = k + 33;
        sb_q.push_back(e);
        busy_ok = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b1;
            if (i < 20) begin
                funct3 = i[2:0]; op_a = $urandom; op_b = $urandom; rd_in = 5'(i);
                if (ready !== 1'b0) busy_ok = 1'b0;
            end else begin
                funct3 = 3'd3; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; rd_in = 5'd9;
                if (ready === 1'b1) begin
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                    acc_cyc = cyc;
                    e.res = 32'hFFFF_FFFE; e.rd = 5'd9; e.cyc = acc_cyc + 2;
                    sb_q.push_back(e);
                    break;
                end
            end
        end
        start = 1'b0;
        check("busy_ready_low", {31'd0, busy_ok}, 32'd1);
        check("held_start_accept_cycle", 32'(acc_cyc), 32'(k + 34));
        drain("busy_drain");

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
